// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit path: sequencer state encoding and
// the default frame width used by both the sequencer and the SPI core.
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP
  } state_t;

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous FIFO between the byte producer and the sequencer. No bypass:
// a full FIFO refuses a push even when a pop happens in the same cycle.
module spi_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_tx_sequencer.sv
// Feeds the SPI core one frame at a time from a small FIFO, holding cs low
// across back-to-back frames and releasing it for a fixed gap after a burst.
module spi_tx_sequencer
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH,
  parameter int DEPTH = 8,
  parameter int GAP   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [WIDTH-1:0]       spi_data,
  output logic                   spi_load,
  output logic                   cs,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = $clog2(GAP + 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_PRELAST = BW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP - 1);

  state_t           state, state_next;
  logic [BW-1:0]    bitcnt, bitcnt_next;
  logic [GW-1:0]    gapcnt, gapcnt_next;
  logic             load_next;
  logic [WIDTH-1:0] data_next;
  logic             push;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] head;

  assign wr_ready = !full;
  assign busy     = (state != S_IDLE);
  assign push     = wr_valid && !full;

  spi_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (spi_load),
    .din   (wr_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // spi_load/spi_data are registered, so the reload decision is taken one
  // cycle early (bitcnt == WIDTH-2); a byte arriving that very cycle is
  // taken straight from wr_data because it is not yet at the FIFO head.
  always_comb begin
    state_next  = state;
    bitcnt_next = bitcnt;
    gapcnt_next = gapcnt;
    load_next   = 1'b0;
    data_next   = empty ? wr_data : head;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_next = S_SETUP;
          load_next  = 1'b1;
        end
      end
      S_SETUP: begin
        state_next  = S_SHIFT;
        bitcnt_next = '0;
      end
      S_SHIFT: begin
        bitcnt_next = bitcnt + 1'b1;
        if (bitcnt == BIT_PRELAST && (!empty || push)) load_next = 1'b1;
        if (bitcnt == BIT_LAST) begin
          bitcnt_next = '0;
          if (!spi_load) begin
            state_next  = S_GAP;
            gapcnt_next = '0;
          end
        end
      end
      S_GAP: begin
        if (gapcnt == GAP_LAST) state_next = S_IDLE;
        else                    gapcnt_next = gapcnt + 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      bitcnt   <= '0;
      gapcnt   <= '0;
      spi_load <= 1'b0;
      spi_data <= '0;
      cs       <= 1'b1;
    end else begin
      state    <= state_next;
      bitcnt   <= bitcnt_next;
      gapcnt   <= gapcnt_next;
      spi_load <= load_next;
      if (load_next) spi_data <= data_next;
      cs       <= !(state_next == S_SETUP || state_next == S_SHIFT);
    end
  end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Directed bench for spi_tx_sequencer: driver tasks feed the FIFO, a monitor
// checks every spi_load word against the expected queue, timing is checked inline.
module tb_spi_tx_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] spi_data;
  logic             spi_load;
  logic             cs;
  logic             busy;
  logic [LW-1:0]    level;

  logic [WIDTH-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  int               load_pos[8];

  spi_tx_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(GAP)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .spi_data (spi_data),
    .spi_load (spi_load),
    .cs       (cs),
    .busy     (busy),
    .level    (level)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // driver: offer one byte until accepted; returns just after the accepting edge
  task automatic write_byte(input logic [WIDTH-1:0] d);
    int   waited = 0;
    logic rdy;
    bit   done = 0;
    wr_data  = d;
    wr_valid = 1'b1;
    while (!done) begin
      @(negedge clock);
      rdy = wr_ready;
      @(posedge clock);
      #1;
      if (rdy) begin
        exp_q.push_back(d);
        done = 1;
      end else if (++waited > 500) begin
        check("write_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      n++;
      @(negedge clock);
    end
    if (n >= 2000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // waits for cs to fall, then measures the low time and load offsets
  task automatic measure_burst(output int first_cyc, output int low_len, output int nl);
    int n = 0;
    nl = 0;
    low_len = 0;
    first_cyc = -1;
    @(negedge clock);
    while (cs && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (n >= 200) begin
      check("cs_fall_timeout", 32'd1, 32'd0);
    end else begin
      first_cyc = cyc;
      while (!cs && low_len < 300) begin
        if (spi_load) begin
          if (nl < 8) load_pos[nl] = low_len;
          nl++;
        end
        low_len++;
        @(negedge clock);
      end
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (!reset && spi_load) begin
      check("load_cs_low", 32'(cs), 32'd0);
      check("level_bound", 32'(level <= LW'(DEPTH)), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_load", 32'd1, 32'd0);
      end else begin
        check("spi_data", 32'(spi_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int acc, first, low, nl, start;

    do_reset();
    @(negedge clock);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_load", 32'(spi_load), 32'd0);
    check("rst_data", 32'(spi_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);

    // single byte
    @(posedge clock); #1;
    fork
      measure_burst(first, low, nl);
      begin write_byte(8'hE9); acc = cyc; end
    join
    check("single_latency", 32'(first), 32'(acc + 1));
    check("single_nloads", 32'(nl), 32'd1);
    check("single_load_pos", 32'(load_pos[0]), 32'd0);
    check("single_cs_low", 32'(low), 32'd9);
    check("single_gap_busy", 32'(busy), 32'd1);
    repeat (GAP) @(negedge clock);
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_idle_cs", 32'(cs), 32'd1);
    wait_idle();

    // back-to-back burst
    @(posedge clock); #1;
    fork
      measure_burst(first, low, nl);
      begin
        write_byte(8'hA5);
        write_byte(8'h3C);
        write_byte(8'hFF);
      end
    join
    check("burst_nloads", 32'(nl), 32'd3);
    check("burst_pos1", 32'(load_pos[1]), 32'd8);
    check("burst_pos2", 32'(load_pos[2]), 32'd16);
    check("burst_cs_low", 32'(low), 32'd25);
    wait_idle();

    // fill to full with 0..11
    @(posedge clock); #1;
    start = cyc;
    fork
      for (int i = 0; i < 12; i++) write_byte(WIDTH'(i));
      begin
        for (int k = 0; k < 12; k++) begin
          @(negedge clock);
          if (k == 8)  begin check("full_c8_level", 32'(level), 32'd7); check("full_c8_ready", 32'(wr_ready), 32'd1); end
          if (k == 9)  begin check("full_c9_level", 32'(level), 32'd8); check("full_c9_ready", 32'(wr_ready), 32'd0); end
          if (k == 10) check("full_c10_ready", 32'(wr_ready), 32'd0);
          if (k == 11) begin check("full_c11_level", 32'(level), 32'd7); check("full_c11_ready", 32'(wr_ready), 32'd1); end
        end
      end
    join
    wait_idle();

    // wrap-around with random producer gaps
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      write_byte(WIDTH'(i * 7 + 3));
    end
    wait_idle();

    // reset during bitcnt 3 of the second frame
    @(posedge clock); #1;
    fork
      begin
        write_byte(8'h10);
        write_byte(8'h20);
        write_byte(8'h30);
        write_byte(8'h40);
      end
      begin
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
      end
    join
    @(negedge clock);
    check("midrst_cs", 32'(cs), 32'd1);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_load", 32'(spi_load), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    write_byte(8'h5A);
    wait_idle();

    // write landing in the first GAP cycle
    @(posedge clock); #1;
    write_byte(8'h11);
    repeat (10) @(posedge clock);
    #1;
    write_byte(8'h81);
    @(negedge clock);
    check("gapwr_level", 32'(level), 32'd1);
    check("gapwr_cs_gap", 32'(cs), 32'd1);
    check("gapwr_busy_gap", 32'(busy), 32'd1);
    @(negedge clock);
    check("gapwr_cs_idle", 32'(cs), 32'd1);
    check("gapwr_busy_idle", 32'(busy), 32'd0);
    check("gapwr_load_idle", 32'(spi_load), 32'd0);
    @(negedge clock);
    check("gapwr_setup_load", 32'(spi_load), 32'd1);
    check("gapwr_setup_cs", 32'(cs), 32'd0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_tx_sequencer.md
# spi_tx_sequencer

Upstream feeder for the SPI master core. Buffers bytes from a producer in a small FIFO and presents them one frame at a time on the core's parallel load input. Frames the burst with chip-select: cs stays low across back-to-back bytes and is released for a fixed gap when the FIFO drains.

## Interface

**Parameters**
- `WIDTH`, 8: frame width in bits. Equals the SPI core shift-register width.
- `DEPTH`, 8: FIFO depth in entries. Must be a power of two, at least 2.
- `GAP`, 2: number of cs-high idle cycles after a burst ends. Must be at least 1.

**Ports**
- `clock` in 1: single clock. Same clock as the SPI core `sck` domain.
- `reset` in 1: synchronous, active-high.
- `wr_data` in WIDTH: byte from the producer.
- `wr_valid` in 1: producer offers `wr_data`.
- `wr_ready` out 1: FIFO can accept. Equals `!full`.
- `spi_data` out WIDTH: parallel word for the SPI core `p_data_in`. Registered.
- `spi_load` out 1: one-cycle pulse. The core latches `spi_data` on this cycle.
- `cs` out 1: chip select, active-low.
- `busy` out 1: high in every state except IDLE.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation

**FIFO**
- A write happens when `wr_valid && wr_ready`.
- A pop happens only on a `spi_load` cycle.
- Push and pop in the same cycle leave `level` unchanged.
- When full, `wr_ready` is 0 even if a pop occurs that cycle. There is no bypass.
- Read and write pointers wrap modulo DEPTH.

**FSM**
- IDLE: `cs`=1, `spi_load`=0.
  - If `level` != 0, go to SETUP.
- SETUP: `cs`=0, `spi_load`=1, `spi_data` = FIFO head (popped), `bitcnt`=0.
  - Always go to SHIFT.
- SHIFT: `cs`=0, `bitcnt` increments each cycle.
  - At `bitcnt`==WIDTH-1 with FIFO non-empty: pop, pulse `spi_load`, reload `spi_data`, reset `bitcnt` to 0, stay in SHIFT (back-to-back frame, cs does not toggle).
  - At `bitcnt`==WIDTH-1 with FIFO empty: go to GAP.
- GAP: `cs`=1, `gapcnt` counts GAP cycles, then go to IDLE.
  - Writes during GAP are accepted, but the next burst starts only after IDLE.

**Counter widths**
- `bitcnt` is $clog2(WIDTH) bits.
- `gapcnt` is $clog2(GAP+1) bits.
- `level` saturates naturally because `wr_ready` gates writes; it never exceeds DEPTH.

**Reset** (from any state, including mid-frame)
- Next cycle: state IDLE, FIFO flushed (`level`=0).
- Outputs: `cs`=1, `spi_load`=0, `spi_data`=0, `busy`=0, `wr_ready`=1.
- A partially shifted frame is abandoned.

## Timing

- Latency: write accepted in cycle N into an empty FIFO in IDLE → `level`=1 in N+1 → SETUP with `spi_load`=1 and `cs`=0 in N+2.
- Frame period is exactly WIDTH cycles, from one `spi_load` to the next within a burst.
- `cs` goes low in the SETUP cycle. It goes high the cycle after the last SHIFT cycle of the final frame.
- Minimum cs-high time between bursts is GAP+1 cycles: GAP cycles in GAP plus one in IDLE.
- A burst of k bytes holds `cs` low for 1+k·WIDTH cycles.
- All outputs are registered except `wr_ready` and `busy`, which are decoded from registered state.

## Structure

- Package `spi_pkg`:
  - state enum {IDLE, SETUP, SHIFT, GAP}.
  - default frame width constant `SPI_WIDTH`=8, shared with the SPI core.
- Sub-module `spi_tx_fifo`: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, level.
  - Reset has the same polarity as the parent.
- Top level holds the FSM, `bitcnt`, `gapcnt` and the `spi_data` register.

## Test plan

- **Single byte:** reset, write 8'hE9 once.
  - `spi_load` pulses at N+2 with `spi_data`=8'hE9.
  - `cs` is low for 9 cycles.
  - `cs` is then high for GAP+1 cycles, and `busy` drops on entry to IDLE.
- **Back-to-back burst:** write 8'hA5, 8'h3C, 8'hFF on consecutive cycles.
  - Three `spi_load` pulses spaced exactly 8 cycles apart, in order.
  - `cs` is low continuously for 25 cycles.
- **Full:** hold `wr_valid` for 12 cycles with incrementing data 0..11, with the SPI side idle or slow.
  - `wr_ready` drops when `level`=8.
  - No data is lost or duplicated; output order is 0..11 across bursts.
- **Wrap-around:** stream 20 bytes with random `wr_valid` gaps.
  - Output sequence equals input sequence.
  - `level` never exceeds 8 or goes negative.
- **Reset mid-frame:** assert `reset` at `bitcnt`=3 of the second byte with 4 bytes queued.
  - Next cycle: `cs`=1, `level`=0, `spi_load`=0.
  - A subsequent single write of 8'h5A is sent normally.
- **Write during GAP:** write 8'h81 during GAP.
  - Accepted (`level`=1).
  - `cs` stays high until GAP completes; SETUP follows one IDLE cycle later.
